// File: rtl/nanorv32_useq_pkg.sv
// nanorv32_useq_pkg
//   Shared constants and encodings for the nanorv32 micro-sequencer.
//   - Default micro-ROM geometry, sequence base addresses and terminator word.
//   - Sequence-kind encoding (2-bit) and sequencer state encoding (1-bit).
//   - Packed debug view of the sequencer state.
package nanorv32_useq_pkg;

  localparam int NANORV32_UROM_ADDR_MSB = 5;
  localparam int NANORV32_UROM_ADDR_W   = NANORV32_UROM_ADDR_MSB + 1;
  localparam int NANORV32_DATA_W        = 32;

  localparam int NANORV32_BOOT_BASE      = 0;
  localparam int NANORV32_IRQ_ENTRY_BASE = 16;
  localparam int NANORV32_IRQ_EXIT_BASE  = 32;
  localparam logic [NANORV32_DATA_W-1:0] NANORV32_END_WORD = 32'h0000_0000;
  localparam int NANORV32_MAX_LEN        = 15;

  typedef enum logic [1:0] {
    KIND_BOOT  = 2'd0,
    KIND_ENTER = 2'd1,
    KIND_EXIT  = 2'd2
  } seq_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } useq_state_e;

  // Debug view: {state, kind}, exported as a 3-bit vector.
  typedef struct packed {
    useq_state_e st;
    seq_kind_e   kind;
  } useq_dbg_t;

endpackage

// File: rtl/nanorv32_useq.sv
// nanorv32_useq
//   Micro-sequencer between fetch and decode. Replays the boot, interrupt-entry
//   and interrupt-exit sequences stored in an external micro-ROM as if they
//   were fetched instructions, while holding the normal fetch path.
//
// Ports
//   clk            core clock
//   rst            synchronous, active-high reset
//   urom_addr      registered micro-ROM address
//   urom_dout      combinational micro-ROM data for urom_addr
//   irq_enter_req  level request for the interrupt-entry sequence
//   irq_exit_req   level request for the interrupt-exit sequence
//   inst           instruction to decode (pass-through of urom_dout)
//   inst_valid     inst is valid
//   inst_ready     decode accepts inst this cycle
//   fetch_hold     stalls / overrides the normal fetch path
//   irq_enter_ack  one-cycle pulse when the entry sequence completes
//   irq_exit_ack   one-cycle pulse when the exit sequence completes
//   seq_err        one-cycle pulse when a sequence aborts on MAX_LEN
//   dbg_state      {state, kind} debug view of the controller
//
// Handshake: a word is transferred on every rising clk edge where
// inst_valid && inst_ready. Once inst_valid is high it stays high, and inst
// stays stable, until that transfer happens (address and count are frozen
// while inst_ready is low). inst_valid never depends on inst_ready.
module nanorv32_useq
  import nanorv32_useq_pkg::*;
#(
  parameter int                 UROM_ADDR_W    = NANORV32_UROM_ADDR_W,
  parameter int                 DATA_W         = NANORV32_DATA_W,
  parameter int                 BOOT_BASE      = NANORV32_BOOT_BASE,
  parameter int                 IRQ_ENTRY_BASE = NANORV32_IRQ_ENTRY_BASE,
  parameter int                 IRQ_EXIT_BASE  = NANORV32_IRQ_EXIT_BASE,
  parameter logic [DATA_W-1:0]  END_WORD       = NANORV32_END_WORD,
  parameter int                 MAX_LEN        = NANORV32_MAX_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [UROM_ADDR_W-1:0] urom_addr,
  input  logic [DATA_W-1:0]      urom_dout,
  input  logic                   irq_enter_req,
  input  logic                   irq_exit_req,
  output logic [DATA_W-1:0]      inst,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic                   fetch_hold,
  output logic                   irq_enter_ack,
  output logic                   irq_exit_ack,
  output logic                   seq_err,
  output logic [2:0]             dbg_state
);

  // Count must be able to hold MAX_LEN itself (the abort condition).
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  useq_state_e            st, st_nxt;
  seq_kind_e              kind, kind_nxt;
  logic [UROM_ADDR_W-1:0] addr_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   boot_pending, boot_pending_nxt;

  logic                   valid_c;
  logic                   enter_ack_c;
  logic                   exit_ack_c;
  logic                   err_c;
  logic                   is_end;
  logic                   at_max;
  useq_dbg_t              dbg;

  assign is_end = (urom_dout == END_WORD);
  assign at_max = (cnt >= CNT_W'(MAX_LEN));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= ST_IDLE;
      kind         <= KIND_BOOT;
      urom_addr    <= UROM_ADDR_W'(BOOT_BASE);
      cnt          <= '0;
      boot_pending <= 1'b1;
    end else begin
      st           <= st_nxt;
      kind         <= kind_nxt;
      urom_addr    <= addr_nxt;
      cnt          <= cnt_nxt;
      boot_pending <= boot_pending_nxt;
    end
  end

  // Next-state and per-cycle outputs
  always_comb begin
    st_nxt           = st;
    kind_nxt         = kind;
    addr_nxt         = urom_addr;
    cnt_nxt          = cnt;
    boot_pending_nxt = boot_pending;
    valid_c          = 1'b0;
    enter_ack_c      = 1'b0;
    exit_ack_c       = 1'b0;
    err_c            = 1'b0;

    case (st)
      ST_IDLE: begin
        // Boot beats a pending exit, and exit beats entry, so a simultaneous
        // enter+exit runs the exit first; the still-held entry request is
        // taken on the next IDLE cycle.
        if (boot_pending) begin
          st_nxt           = ST_RUN;
          kind_nxt         = KIND_BOOT;
          addr_nxt         = UROM_ADDR_W'(BOOT_BASE);
          cnt_nxt          = '0;
          boot_pending_nxt = 1'b0;
        end else if (irq_exit_req) begin
          st_nxt   = ST_RUN;
          kind_nxt = KIND_EXIT;
          addr_nxt = UROM_ADDR_W'(IRQ_EXIT_BASE);
          cnt_nxt  = '0;
        end else if (irq_enter_req) begin
          st_nxt   = ST_RUN;
          kind_nxt = KIND_ENTER;
          addr_nxt = UROM_ADDR_W'(IRQ_ENTRY_BASE);
          cnt_nxt  = '0;
        end
      end

      ST_RUN: begin
        if (is_end || at_max) begin
          // Terminator (or runaway sequence): finish without issuing.
          // A runaway still acks so the requester cannot deadlock.
          st_nxt      = ST_IDLE;
          err_c       = !is_end;
          enter_ack_c = (kind == KIND_ENTER);
          exit_ack_c  = (kind == KIND_EXIT);
        end else begin
          valid_c = 1'b1;
          if (inst_ready) begin
            addr_nxt = urom_addr + UROM_ADDR_W'(1);  // wraps modulo 2^UROM_ADDR_W
            cnt_nxt  = cnt + CNT_W'(1);
          end
        end
      end

      default: st_nxt = ST_IDLE;
    endcase
  end

  // Outputs are forced to their reset values while rst is high, so a reset
  // in the middle of a sequence takes effect in the same cycle.
  assign inst          = urom_dout;
  assign inst_valid    = valid_c && !rst;
  assign fetch_hold    = rst || boot_pending || (st == ST_RUN);
  assign irq_enter_ack = enter_ack_c && !rst;
  assign irq_exit_ack  = exit_ack_c && !rst;
  assign seq_err       = err_c && !rst;

  assign dbg.st    = st;
  assign dbg.kind  = kind;
  assign dbg_state = dbg;

endmodule

// File: tb/tb_nanorv32_useq.sv
// tb_nanorv32_useq
//   Directed testbench for nanorv32_useq with a behavioural micro-ROM.
//   Covers boot, backpressure, interrupt entry, simultaneous enter/exit,
//   missing terminator abort and reset in the middle of a sequence.
module tb_nanorv32_useq;

  localparam logic [31:0] W_A  = 32'hA000_0013;
  localparam logic [31:0] W_B  = 32'hB000_0093;
  localparam logic [31:0] W_C  = 32'hC000_0113;
  localparam logic [31:0] W_X  = 32'h1234_5673;
  localparam logic [31:0] W_Y  = 32'h2345_6783;
  localparam logic [31:0] W_Z  = 32'h3456_7893;
  localparam logic [31:0] W_E1 = 32'hE1E1_0073;
  localparam logic [31:0] W_RUN = 32'hE100_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  urom_addr;
  logic [31:0] urom_dout;
  logic        irq_enter_req;
  logic        irq_exit_req;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_hold;
  logic        irq_enter_ack;
  logic        irq_exit_ack;
  logic        seq_err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  logic [31:0] rom [0:63];
  assign urom_dout = rom[urom_addr];

  nanorv32_useq dut (
    .clk           (clk),
    .rst           (rst),
    .urom_addr     (urom_addr),
    .urom_dout     (urom_dout),
    .irq_enter_req (irq_enter_req),
    .irq_exit_req  (irq_exit_req),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .fetch_hold    (fetch_hold),
    .irq_enter_ack (irq_enter_ack),
    .irq_exit_ack  (irq_exit_ack),
    .seq_err       (seq_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int enter_acks = 0;
  int exit_acks = 0;
  int err_pulses = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  // Record every transfer and every pulse as seen on the clock edge.
  always @(posedge clk) begin
    if (inst_valid && inst_ready) got_q.push_back(inst);
    if (irq_enter_ack) enter_acks++;
    if (irq_exit_ack) exit_acks++;
    if (seq_err) err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are checked there.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0]  = W_A;
    rom[1]  = W_B;
    rom[2]  = W_C;
    rom[16] = W_X;
    rom[32] = W_E1;
    rst = 1'b1;
    irq_enter_req = 1'b0;
    irq_exit_req  = 1'b0;
    inst_ready    = 1'b1;
    tick;
    tick;

    // Reset state
    chk("rst_valid", inst_valid, 0);
    chk("rst_hold", fetch_hold, 1);
    chk("rst_addr", urom_addr, 0);
    chk("rst_enter_ack", irq_enter_ack, 0);
    chk("rst_exit_ack", irq_exit_ack, 0);
    chk("rst_err", seq_err, 0);
    chk("rst_dbg", dbg_state, 3'b000);

    // Boot with backpressure on B
    rst = 1'b0;
    tick;
    chk("boot_valid_a", inst_valid, 1);
    chk("boot_inst_a", inst, W_A);
    chk("boot_hold", fetch_hold, 1);
    chk("boot_dbg", dbg_state, 3'b100);
    exp_q.push_back(W_A);
    tick;
    chk("boot_inst_b", inst, W_B);
    chk("boot_addr_b", urom_addr, 1);
    exp_q.push_back(W_B);
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("bp_inst", inst, W_B);
      chk("bp_addr", urom_addr, 1);
      chk("bp_valid", inst_valid, 1);
    end
    inst_ready = 1'b1;
    tick;
    chk("boot_inst_c", inst, W_C);
    chk("boot_addr_c", urom_addr, 2);
    exp_q.push_back(W_C);
    tick;
    chk("boot_end_valid", inst_valid, 0);
    chk("boot_end_hold", fetch_hold, 1);
    chk("boot_end_enter_ack", irq_enter_ack, 0);
    chk("boot_end_exit_ack", irq_exit_ack, 0);
    tick;
    chk("boot_done_hold", fetch_hold, 0);
    chk("boot_done_dbg", dbg_state, 3'b000);
    chk("boot_issue_cnt", got_q.size(), 3);
    chk("boot_no_acks", enter_acks + exit_acks, 0);

    // Interrupt entry
    irq_enter_req = 1'b1;
    tick;
    chk("ent_valid", inst_valid, 1);
    chk("ent_inst", inst, W_X);
    chk("ent_addr", urom_addr, 16);
    chk("ent_dbg", dbg_state, 3'b101);
    exp_q.push_back(W_X);
    tick;
    chk("ent_ack", irq_enter_ack, 1);
    chk("ent_end_valid", inst_valid, 0);
    chk("ent_no_exit_ack", irq_exit_ack, 0);
    irq_enter_req = 1'b0;
    tick;
    chk("ent_ack_drop", irq_enter_ack, 0);
    chk("ent_idle_hold", fetch_hold, 0);
    tick;
    tick;
    chk("ent_stay_idle", dbg_state, 3'b001);
    chk("ent_stay_hold", fetch_hold, 0);
    chk("ent_ack_cnt", enter_acks, 1);

    // Simultaneous enter + exit: exit first
    irq_enter_req = 1'b1;
    irq_exit_req  = 1'b1;
    tick;
    chk("sim_exit_dbg", dbg_state, 3'b110);
    chk("sim_exit_inst", inst, W_E1);
    exp_q.push_back(W_E1);
    tick;
    chk("sim_exit_ack", irq_exit_ack, 1);
    chk("sim_exit_no_enter_ack", irq_enter_ack, 0);
    irq_exit_req = 1'b0;
    tick;
    chk("sim_gap_valid", inst_valid, 0);
    chk("sim_gap_hold", fetch_hold, 0);
    chk("sim_gap_dbg", dbg_state, 3'b010);
    tick;
    chk("sim_ent_dbg", dbg_state, 3'b101);
    chk("sim_ent_inst", inst, W_X);
    exp_q.push_back(W_X);
    tick;
    chk("sim_ent_ack", irq_enter_ack, 1);
    irq_enter_req = 1'b0;
    tick;
    chk("sim_done_dbg", dbg_state, 3'b001);

    // Missing terminator in the exit sequence
    for (int i = 0; i < 16; i++) rom[32 + i] = W_RUN + i;
    irq_exit_req = 1'b1;
    tick;
    chk("mt_addr0", urom_addr, 32);
    for (int i = 0; i < 15; i++) begin
      chk("mt_inst", inst, W_RUN + i);
      chk("mt_valid", inst_valid, 1);
      exp_q.push_back(W_RUN + i);
      tick;
    end
    chk("mt_err", seq_err, 1);
    chk("mt_exit_ack", irq_exit_ack, 1);
    chk("mt_valid_cut", inst_valid, 0);
    chk("mt_addr_end", urom_addr, 47);
    irq_exit_req = 1'b0;
    tick;
    chk("mt_err_drop", seq_err, 0);
    chk("mt_idle_dbg", dbg_state, 3'b010);

    // Reset in the middle of the entry sequence
    rom[17] = W_Y;
    rom[18] = W_Z;
    rom[19] = 32'h0;
    irq_enter_req = 1'b1;
    tick;
    tick;
    tick;
    exp_q.push_back(W_X);
    exp_q.push_back(W_Y);
    chk("mr_inst_z", inst, W_Z);
    rst = 1'b1;
    #1;
    chk("mr_valid", inst_valid, 0);
    chk("mr_hold", fetch_hold, 1);
    chk("mr_enter_ack", irq_enter_ack, 0);
    tick;
    chk("mr_addr", urom_addr, 0);
    chk("mr_dbg", dbg_state, 3'b000);
    irq_enter_req = 1'b0;
    rst = 1'b0;
    tick;
    chk("mr_boot_addr", urom_addr, 0);
    chk("mr_boot_inst", inst, W_A);
    chk("mr_boot_valid", inst_valid, 1);
    exp_q.push_back(W_A);
    exp_q.push_back(W_B);
    exp_q.push_back(W_C);
    tick;
    tick;
    tick;
    tick;
    chk("mr_boot_done_hold", fetch_hold, 0);

    // Final scoreboard
    chk("issue_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("issue_%0d", i), got_q[i], exp_q[i]);
    chk("total_enter_acks", enter_acks, 2);
    chk("total_exit_acks", exit_acks, 2);
    chk("total_err", err_pulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
